// File: rtl/risc_v_pkg.sv
// Shared RISC-V decode definitions: opcodes, funct7 values, ALU and M-extension op codes.
package risc_v_pkg;

    localparam logic [6:0] OPC_R      = 7'h33;
    localparam logic [6:0] OPC_I_ALU  = 7'h13;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    localparam logic [6:0] F7_BASE   = 7'h00;
    localparam logic [6:0] F7_ALT    = 7'h20;
    localparam logic [6:0] F7_MULDIV = 7'h01;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0, ALU_SUB  = 4'h1, ALU_XOR  = 4'h2, ALU_OR   = 4'h3,
        ALU_AND  = 4'h4, ALU_SLL  = 4'h5, ALU_SRL  = 4'h6, ALU_SRA  = 4'h7,
        ALU_SLT  = 4'h8, ALU_SLTU = 4'h9, ALU_BEQ  = 4'hA, ALU_BNE  = 4'hB,
        ALU_BLT  = 4'hC, ALU_BGE  = 4'hD, ALU_BLTU = 4'hE, ALU_BGEU = 4'hF
    } alu_op_e;

    typedef enum logic [2:0] {
        MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3,
        MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM    = 3'd6, MD_REMU  = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_e;

    // Shared R/I arithmetic funct3 mapping; callers decide when SUB and SRA apply.
    function automatic alu_op_e arith_op(input logic [2:0] funct3,
                                         input logic use_sub,
                                         input logic use_sra);
        case (funct3)
            3'd0:    return use_sub ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return use_sra ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Radix-2 multiply/divide datapath on operand magnitudes, with final sign fix-up.
// hi/lo hold {product upper, product lower} for multiply and {remainder, quotient} for divide.
module md_iter_core #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            step_i,
    input  logic            is_div_i,
    input  logic            sel_hi_i,
    input  logic            neg_lo_i,
    input  logic            neg_hi_i,
    input  logic [XLEN-1:0] a_mag_i,
    input  logic [XLEN-1:0] b_mag_i,
    output logic            last_o,
    output logic [XLEN-1:0] result_o
);
    localparam int CW = $clog2(XLEN);

    logic [XLEN-1:0]   hi_reg, lo_reg, b_reg;
    logic [CW-1:0]     cnt_reg;
    logic              is_div_reg, sel_hi_reg, neg_lo_reg, neg_hi_reg;

    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic              div_ge;
    logic [XLEN-1:0]   hi_next, lo_next;
    logic [2*XLEN-1:0] prod, prod_fix;

    assign last_o = step_i && (cnt_reg == CW'(XLEN - 1));

    // One iteration: shift-add multiply or restoring divide step.
    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : {(XLEN+1){1'b0}});
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_reg};
        div_ge    = ~div_diff[XLEN];
        if (is_div_reg) begin
            hi_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_next = {lo_reg[XLEN-2:0], div_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo_reg[XLEN-1:1]};
        end
    end

    // Sign fix-up on the values the final step produces, so the result is ready at the last edge.
    always_comb begin
        prod     = {hi_next, lo_next};
        prod_fix = neg_lo_reg ? -prod : prod;
        if (is_div_reg) begin
            if (sel_hi_reg) result_o = neg_hi_reg ? -hi_next : hi_next;
            else            result_o = neg_lo_reg ? -lo_next : lo_next;
        end else begin
            result_o = sel_hi_reg ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        end
    end

    // Operand/config capture on start, then one step per enabled cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hi_reg     <= '0;
            lo_reg     <= '0;
            b_reg      <= '0;
            cnt_reg    <= '0;
            is_div_reg <= 1'b0;
            sel_hi_reg <= 1'b0;
            neg_lo_reg <= 1'b0;
            neg_hi_reg <= 1'b0;
        end else if (start_i) begin
            hi_reg     <= '0;
            lo_reg     <= a_mag_i;
            b_reg      <= b_mag_i;
            cnt_reg    <= '0;
            is_div_reg <= is_div_i;
            sel_hi_reg <= sel_hi_i;
            neg_lo_reg <= neg_lo_i;
            neg_hi_reg <= neg_hi_i;
        end else if (step_i) begin
            hi_reg  <= hi_next;
            lo_reg  <= lo_next;
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

endmodule

// File: rtl/alu_md_controller.sv
// ALU/branch decode plus RV32M sequencing: stalls fetch while the iterative engine runs.
// XLEN must be even and at least 8.
module alu_md_controller
    import risc_v_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_DIV0 = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            valid_i,
    input  logic            flush_i,
    input  logic [6:0]      op_code_i,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    output logic            alu_src_o,
    output logic [3:0]      alu_op_o,
    output logic            md_sel_o,
    output logic [XLEN-1:0] md_result_o,
    output logic            md_valid_o,
    output logic            stall_o
);
    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e       state_reg, state_next;
    logic [XLEN-1:0] result_reg;
    md_op_e          md_op;
    logic            m_req, accept, is_div, a_signed, b_signed, a_neg, b_neg;
    logic            b_zero, ovf, bypass, sel_hi, neg_lo, neg_hi;
    logic [XLEN-1:0] a_mag, b_mag, byp_val, core_result;
    logic            core_last, core_step;
    alu_op_e         alu_op;

    // Base ALU/branch decode, independent of the M-extension sequencer.
    always_comb begin
        alu_src_o = 1'b0;
        alu_op    = ALU_ADD;
        case (op_code_i)
            OPC_R: begin
                if (funct7_i != F7_MULDIV)
                    alu_op = arith_op(funct3_i, funct7_i == F7_ALT, funct7_i[5]);
            end
            OPC_I_ALU: begin
                alu_src_o = 1'b1;
                alu_op    = arith_op(funct3_i, 1'b0, funct7_i[5]);
            end
            OPC_LOAD, OPC_STORE: alu_src_o = 1'b1;
            OPC_BRANCH: begin
                case (funct3_i)
                    3'd0:    alu_op = ALU_BEQ;
                    3'd1:    alu_op = ALU_BNE;
                    3'd4:    alu_op = ALU_BLT;
                    3'd5:    alu_op = ALU_BGE;
                    3'd6:    alu_op = ALU_BLTU;
                    3'd7:    alu_op = ALU_BGEU;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: ;
        endcase
    end
    assign alu_op_o = alu_op;

    assign m_req    = valid_i && (op_code_i == OPC_R) && (funct7_i == F7_MULDIV);
    assign md_sel_o = m_req;
    assign md_op    = md_op_e'(funct3_i);
    assign is_div   = funct3_i[2];

    // Operand signedness per M op; MUL low half is sign-agnostic but treated as signed.
    always_comb begin
        a_signed = 1'b0;
        b_signed = 1'b0;
        case (md_op)
            MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            MD_MULHSU: a_signed = 1'b1;
            default: ;
        endcase
    end

    assign a_neg  = a_signed && rs1_i[XLEN-1];
    assign b_neg  = b_signed && rs2_i[XLEN-1];
    assign a_mag  = a_neg ? -rs1_i : rs1_i;
    assign b_mag  = b_neg ? -rs2_i : rs2_i;
    assign b_zero = (rs2_i == '0);
    assign ovf    = a_signed && (rs1_i == MIN_VAL) && (rs2_i == '1);
    // Divide by zero must keep an all-ones quotient, so its sign is never flipped.
    assign neg_lo = is_div ? ((a_neg ^ b_neg) && !b_zero) : (a_neg ^ b_neg);
    assign neg_hi = is_div ? a_neg : (a_neg ^ b_neg);
    assign sel_hi = is_div ? funct3_i[1] : (funct3_i[1:0] != 2'd0);
    assign bypass = FAST_DIV0 && is_div && (b_zero || ovf);
    // funct3[1] selects the remainder for divide ops.
    assign byp_val = b_zero ? (funct3_i[1] ? rs1_i : '1)
                            : (funct3_i[1] ? '0 : rs1_i);

    assign accept    = (state_reg == MD_IDLE) && m_req && !flush_i;
    assign core_step = (state_reg == MD_BUSY);

    md_iter_core #(.XLEN(XLEN)) u_core (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .start_i  (accept),
        .step_i   (core_step),
        .is_div_i (is_div),
        .sel_hi_i (sel_hi),
        .neg_lo_i (neg_lo),
        .neg_hi_i (neg_hi),
        .a_mag_i  (a_mag),
        .b_mag_i  (b_mag),
        .last_o   (core_last),
        .result_o (core_result)
    );

    // Sequencer next state and handshake outputs; flush overrides everything.
    always_comb begin
        state_next = state_reg;
        stall_o    = 1'b0;
        md_valid_o = 1'b0;
        case (state_reg)
            MD_IDLE: begin
                stall_o = m_req;
                if (accept) state_next = bypass ? MD_DONE : MD_BUSY;
            end
            MD_BUSY: begin
                stall_o = 1'b1;
                if (core_last) state_next = MD_DONE;
            end
            MD_DONE: begin
                md_valid_o = 1'b1;
                state_next = MD_IDLE;
            end
            default: state_next = MD_IDLE;
        endcase
        if (flush_i) begin
            state_next = MD_IDLE;
            md_valid_o = 1'b0;
        end
    end

    // State register and result holding register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg  <= MD_IDLE;
            result_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (accept && bypass)
                result_reg <= byp_val;
            else if (core_last && !flush_i)
                result_reg <= core_result;
        end
    end
    assign md_result_o = result_reg;

endmodule

// File: tb/tb_alu_md_controller.sv
// Directed bench for alu_md_controller with a result scoreboard and immediate assertions.
module tb_alu_md_controller;
    logic        clk_i = 1'b0;
    logic        rst_ni, valid_i, flush_i;
    logic [6:0]  op_code_i, funct7_i;
    logic [2:0]  funct3_i;
    logic [31:0] rs1_i, rs2_i;
    logic        alu_src_o, md_sel_o, md_valid_o, stall_o;
    logic [3:0]  alu_op_o;
    logic [31:0] md_result_o;

    int errors = 0;
    int checks = 0;
    int pushes = 0;
    int pulses = 0;
    logic [31:0] sb[$];

    alu_md_controller #(.XLEN(32), .FAST_DIV0(1'b1)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .flush_i(flush_i),
        .op_code_i(op_code_i), .funct3_i(funct3_i), .funct7_i(funct7_i),
        .rs1_i(rs1_i), .rs2_i(rs2_i), .alu_src_o(alu_src_o), .alu_op_o(alu_op_o),
        .md_sel_o(md_sel_o), .md_result_o(md_result_o), .md_valid_o(md_valid_o),
        .stall_o(stall_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (md_valid_o === 1'b1) pulses++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        valid_i = 1'b1; op_code_i = opc; funct3_i = f3; funct7_i = f7; rs1_i = a; rs2_i = b;
        #1;
    endtask

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
        drive(7'h33, f3, 7'h01, a, b);
        sb.push_back(exp);
        pushes++;
        $display("issue f3=%0d rs1=%h rs2=%h expect=%h", f3, a, b, exp);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input int exp_stall);
        int k = 0;
        int st = 0;
        logic [31:0] exp;
        do begin
            if (stall_o === 1'b1) st++;
            @(posedge clk_i); #1;
            k++;
        end while (md_valid_o !== 1'b1 && k < 200);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hxxxx_xxxx;
        check({tag, " latency"}, k, exp_lat);
        check({tag, " stall_cycles"}, st, exp_stall);
        check({tag, " stall_at_done"}, {31'b0, stall_o}, 32'd0);
        check({tag, " result"}, md_result_o, exp);
        $display("done %s lat=%0d result=%h", tag, k, md_result_o);
        valid_i = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0; valid_i = 1'b0; flush_i = 1'b0;
        op_code_i = '0; funct3_i = '0; funct7_i = '0; rs1_i = '0; rs2_i = '0;
        repeat (2) @(posedge clk_i); #1;
        check("reset md_result", md_result_o, 32'd0);
        check("reset md_valid", {31'b0, md_valid_o}, 32'd0);
        check("reset stall", {31'b0, stall_o}, 32'd0);
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Base decode vectors.
        drive(7'h33, 3'd0, 7'h20, 0, 0);
        check("SUB alu_op", {28'b0, alu_op_o}, 32'h1);
        check("SUB alu_src", {31'b0, alu_src_o}, 32'd0);
        drive(7'h13, 3'd5, 7'h20, 0, 0);
        check("SRAI alu_op", {28'b0, alu_op_o}, 32'h7);
        check("SRAI alu_src", {31'b0, alu_src_o}, 32'd1);
        drive(7'h63, 3'd7, 7'h00, 0, 0);
        check("BGEU alu_op", {28'b0, alu_op_o}, 32'hF);
        check("BGEU alu_src", {31'b0, alu_src_o}, 32'd0);
        drive(7'h63, 3'd2, 7'h00, 0, 0);
        check("BR f3=2 alu_op", {28'b0, alu_op_o}, 32'h0);
        drive(7'h13, 3'd0, 7'h20, 0, 0);
        check("ADDI alu_op", {28'b0, alu_op_o}, 32'h0);
        drive(7'h37, 3'd5, 7'h20, 0, 0);
        check("LUI alu_op", {28'b0, alu_op_o}, 32'h0);
        check("LUI stall", {31'b0, stall_o}, 32'd0);
        check("LUI md_sel", {31'b0, md_sel_o}, 32'd0);
        valid_i = 1'b0;
        @(posedge clk_i); #1;

        // Iterative multiply.
        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        check("MUL stall_at_accept", {31'b0, stall_o}, 32'd1);
        check("MUL md_sel", {31'b0, md_sel_o}, 32'd1);
        check("MUL alu_op", {28'b0, alu_op_o}, 32'h0);
        wait_done("MUL", 33, 33);
        @(posedge clk_i); #1;
        issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_done("MULHU", 33, 33);
        @(posedge clk_i); #1;
        issue(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF);
        wait_done("MULH", 33, 33);
        @(posedge clk_i); #1;
        issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done("MULHSU", 33, 33);
        @(posedge clk_i); #1;

        // Iterative divide.
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        wait_done("DIVU", 33, 33);
        @(posedge clk_i); #1;
        issue(3'd7, 32'd100, 32'd7, 32'd2);
        wait_done("REMU", 33, 33);
        @(posedge clk_i); #1;
        issue(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        wait_done("REM", 33, 33);
        @(posedge clk_i); #1;
        issue(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        wait_done("DIV", 33, 33);
        @(posedge clk_i); #1;

        // Fast special cases.
        issue(3'd4, 32'd12345, 32'd0, 32'hFFFF_FFFF);
        wait_done("DIV0", 1, 1);
        @(posedge clk_i); #1;
        issue(3'd6, 32'd5, 32'd0, 32'd5);
        wait_done("REM0", 1, 1);
        @(posedge clk_i); #1;
        issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        wait_done("DIVOVF", 1, 1);
        @(posedge clk_i); #1;
        issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        wait_done("REMOVF", 1, 1);
        @(posedge clk_i); #1;

        // Back-to-back: DIV presented during the MUL DONE cycle, accepted one cycle later.
        issue(3'd0, 32'd1000, 32'd3000, 32'd3000000);
        wait_done("B2B MUL", 33, 33);
        issue(3'd4, 32'd1000, 32'hFFFF_FFF6, 32'hFFFF_FF9C);
        wait_done("B2B DIV", 34, 33);
        @(posedge clk_i); #1;

        // Flush at BUSY count 10.
        drive(7'h33, 3'd0, 7'h01, 32'd9, 32'd9);
        repeat (11) begin @(posedge clk_i); #1; end
        check("flush pre stall", {31'b0, stall_o}, 32'd1);
        flush_i = 1'b1; valid_i = 1'b0;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        check("flush stall", {31'b0, stall_o}, 32'd0);
        check("flush md_valid", {31'b0, md_valid_o}, 32'd0);
        check("flush result hold", md_result_o, 32'hFFFF_FF9C);
        repeat (40) @(posedge clk_i);
        #1;

        // Reset at BUSY count 20.
        drive(7'h33, 3'd0, 7'h01, 32'd11, 32'd13);
        repeat (21) begin @(posedge clk_i); #1; end
        rst_ni = 1'b0; valid_i = 1'b0;
        #1;
        check("rst md_result", md_result_o, 32'd0);
        check("rst md_valid", {31'b0, md_valid_o}, 32'd0);
        check("rst stall", {31'b0, stall_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
        issue(3'd0, 32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
        wait_done("post-rst MUL", 33, 33);
        repeat (5) @(posedge clk_i);
        #1;

        check("pulse count", pulses, pushes);
        check("scoreboard empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
